uart_tx_sched: RTL and testbench

- Round-robin scheduler that shares one 8-bit UART transmitter (tx_start / din / tx_done_tick handshake) between N_REQ requesters.
- Each requester sends a frame: one or more bytes, terminated by a last flag.
- A granted frame is transmitted atomically; bytes from different requesters never interleave.
- Sits between game/debug message sources and the UART TX datapath.

---
 rtl/uart_sched_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/uart_tx_sched.sv | 158 +++++++++++++++
 tb/tb_uart_tx_sched.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sched_pkg.sv
// Shared types and helpers for the round-robin UART TX scheduler.
package uart_sched_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} sched_state_t;

    localparam int DBIT_DEFAULT = 8;

    // Explicit compare so non-power-of-two requester counts wrap correctly.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: first set request at or after ptr_i, with wrap.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic             valid_o,
    output logic [PTR_W-1:0] idx_o
);

    always_comb begin
        int j;
        gnt_o   = '0;
        valid_o = 1'b0;
        idx_o   = '0;
        j       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!valid_o && j < N_REQ && req_i[j]) begin
                valid_o  = 1'b1;
                idx_o    = PTR_W'(j);
                gnt_o[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between N_REQ frame sources; frames are sent atomically.
// Optional LOAD-stall abort is enabled with `define UART_SCHED_TIMEOUT_EN.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DBIT        = DBIT_DEFAULT,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*DBIT-1:0] req_data,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ-1:0]      req_last,
    output logic [N_REQ-1:0]      req_ready,
    output logic [N_REQ-1:0]      gnt,
    output logic                  tx_start,
    output logic [DBIT-1:0]       tx_din,
    input  logic                  tx_done_tick,
    output logic                  busy,
    output logic                  abort_tick
);

    localparam int PTR_W = $clog2(N_REQ);

    sched_state_t     state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] gidx_q, gidx_d;
    logic [DBIT-1:0]  din_q, din_d;
    logic             last_q, last_d;

    logic [N_REQ-1:0] arb_gnt;
    logic             arb_valid;
    logic [PTR_W-1:0] arb_idx;
    logic             cur_valid;
    logic             cur_last;
    logic [DBIT-1:0]  cur_data;
    logic             timeout_hit;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .valid_o (arb_valid),
        .idx_o   (arb_idx)
    );

    assign cur_valid = req_valid[gidx_q];
    assign cur_last  = req_last[gidx_q];
    assign cur_data  = req_data[int'(gidx_q)*DBIT +: DBIT];

`ifdef UART_SCHED_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC) > 0) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             abort_q;

    // Counter is zero outside LOAD, so it is already cleared on every LOAD entry.
    always_comb begin
        cnt_d = '0;
        if (state_q == LOAD && !cur_valid) cnt_d = cnt_q + 1'b1;
    end

    assign timeout_hit = (state_q == LOAD) && !cur_valid && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign abort_tick  = abort_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            abort_q <= timeout_hit;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYC == 0);
    assign timeout_hit    = 1'b0;
    assign abort_tick     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            gidx_q  <= '0;
            din_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            din_q   <= din_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        din_d   = din_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d = LOAD;
                    gnt_d   = arb_gnt;
                    gidx_d  = arb_idx;
                end
            end
            LOAD: begin
                if (cur_valid) begin
                    din_d   = cur_data;
                    last_d  = cur_last;
                    state_d = SEND;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = PTR_W'(rr_next(int'(gidx_q), N_REQ));
                end
            end
            SEND: state_d = WAIT;
            WAIT: begin
                if (tx_done_tick) begin
                    if (last_q) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        ptr_d   = PTR_W'(rr_next(int'(gidx_q), N_REQ));
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Every output is a decode of registered state, never of an input.
    always_comb begin
        gnt       = gnt_q;
        req_ready = (state_q == LOAD) ? gnt_q : '0;
        tx_start  = (state_q == SEND);
        tx_din    = din_q;
        busy      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: requester queues drive frames, a monitor checks each tx_start.
`timescale 1ns/1ps
module tb_uart_tx_sched;

    localparam int NR    = 4;
    localparam int TXLAT = 3;

    typedef struct {
        logic [7:0] d;
        bit         last;
        int         delay;
    } beat_t;

    typedef struct {
        logic [7:0]    d;
        logic [NR-1:0] g;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NR-1:0]   req = '0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_last = '0;
    logic [NR*8-1:0] req_data = '0;
    logic            tx_done_tick = 1'b0;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   gnt;
    logic            tx_start;
    logic [7:0]      tx_din;
    logic            busy;
    logic            abort_tick;

    beat_t         reqQ[NR][$];
    exp_t          expQ[$];
    exp_t          expItem;
    beat_t         headBeat;
    logic [NR-1:0] rdyS = '0;
    logic [NR-1:0] hsS = '0;
    int            passCnt = 0;
    int            totalCnt = 0;
    int            txStartCount = 0;
    int            doneCount = 0;
    int            txCnt = 0;
    bit            txBusy = 1'b0;

    uart_tx_sched #(.N_REQ(NR), .DBIT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_data     (req_data),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .gnt          (gnt),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .tx_done_tick (tx_done_tick),
        .busy         (busy),
        .abort_tick   (abort_tick)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req_v);
        totalCnt++;
        if (act === req_v) passCnt++;
        else $display("[TB] FAIL %s: got %0h, required %0h", name, act, req_v);
    endtask

    task automatic failWait(input string name, input int budget);
        totalCnt++;
        $display("[TB] FAIL %s: no event within %0d cycles, required the event", name, budget);
    endtask

    function automatic bit queuesEmpty();
        for (int i = 0; i < NR; i++) if (reqQ[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Queue one frame on a requester; the first byte can be held back for `stall` granted cycles.
    task automatic applyStimulus(input int who, input int n, input logic [23:0] bytes, input int stall);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.d     = bytes[k*8 +: 8];
            b.last  = (k == n - 1);
            b.delay = (k == 0) ? stall : 0;
            reqQ[who].push_back(b);
        end
    endtask

    task automatic expectTx(input logic [7:0] d, input logic [NR-1:0] g);
        exp_t e;
        e.d = d;
        e.g = g;
        expQ.push_back(e);
    endtask

    task automatic waitIdle(input string name, input int budget);
        int k;
        bit done;
        k    = 0;
        done = 1'b0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
            done = (expQ.size() == 0) && queuesEmpty() && !busy;
        end
        if (!done) failWait(name, budget);
    endtask

    task automatic waitGnt(input string name, input logic [NR-1:0] g, input int budget);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (gnt == '0 && k < budget);
        if (gnt == '0) failWait(name, budget);
        else checkOutput(name, 32'(gnt), 32'(g));
    endtask

    task automatic waitCount(input string name, input bit useDone, input int target, input int budget);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (((useDone ? doneCount : txStartCount) < target) && k < budget);
        if ((useDone ? doneCount : txStartCount) < target) failWait(name, budget);
    endtask

    // Transmitter model: after each tx_start, pulse tx_done_tick TXLAT+1 cycles later.
    always @(posedge clk) begin
        #1;
        tx_done_tick = 1'b0;
        if (!rst) begin
            txBusy = 1'b0;
        end else if (txBusy) begin
            if (txCnt == 0) begin
                tx_done_tick = 1'b1;
                doneCount++;
                txBusy = 1'b0;
            end else begin
                txCnt--;
            end
        end else if (tx_start) begin
            txBusy = 1'b1;
            txCnt  = TXLAT;
        end
    end

    // Requester handshake is sampled mid-cycle so it matches what the DUT sees at the next edge.
    always @(negedge clk) begin
        rdyS = req_ready;
        hsS  = req_valid & req_ready;
    end

    // Requester driver: presents the head of each queue, pops on handshake, counts down stalls.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NR; i++) begin
            if (hsS[i] && reqQ[i].size() > 0) begin
                void'(reqQ[i].pop_front());
            end else if (rdyS[i] && reqQ[i].size() > 0 && reqQ[i][0].delay > 0) begin
                headBeat       = reqQ[i][0];
                headBeat.delay = headBeat.delay - 1;
                reqQ[i][0]     = headBeat;
            end
            if (reqQ[i].size() > 0) begin
                req[i]            = 1'b1;
                req_valid[i]      = (reqQ[i][0].delay == 0);
                req_data[i*8 +: 8] = reqQ[i][0].d;
                req_last[i]       = reqQ[i][0].last;
            end else begin
                req[i]            = 1'b0;
                req_valid[i]      = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_last[i]       = 1'b0;
            end
        end
        hsS = '0;
    end

    // Monitor: every tx_start pops the next expected byte and owner from the scoreboard.
    always @(negedge clk) begin
        if (rst && tx_start) begin
            txStartCount++;
            if (expQ.size() == 0) begin
                totalCnt++;
                $display("[TB] FAIL tx_unexpected: got tx_din %0h gnt %0h, required no transmission", tx_din, gnt);
            end else begin
                expItem = expQ.pop_front();
                checkOutput("tx_din", 32'(tx_din), 32'(expItem.d));
                checkOutput("tx_gnt", 32'(gnt), 32'(expItem.g));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_gnt", 32'(gnt), 0);
        checkOutput("rst_ready", 32'(req_ready), 0);
        checkOutput("rst_tx_start", 32'(tx_start), 0);
        checkOutput("rst_tx_din", 32'(tx_din), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_abort", 32'(abort_tick), 0);
        rst = 1'b1;

        // Single requester, three-byte frame.
        @(negedge clk);
        applyStimulus(0, 3, 24'h434241, 0);
        expectTx(8'h41, 4'b0001);
        expectTx(8'h42, 4'b0001);
        expectTx(8'h43, 4'b0001);
        waitGnt("single_gnt", 4'b0001, 10);
        waitCount("single_done", 1'b1, 3, 100);
        checkOutput("single_busy_hold", 32'(busy), 1);
        @(negedge clk);
        checkOutput("single_busy_drop", 32'(busy), 0);
        checkOutput("single_gnt_clear", 32'(gnt), 0);
        waitIdle("single_idle", 50);

        // Pointer fairness: after requester 2, scan starts at 3 and wraps to 0.
        applyStimulus(2, 1, 24'h0000A0, 0);
        expectTx(8'hA0, 4'b0100);
        waitIdle("fair_first", 50);
        applyStimulus(0, 1, 24'h0000B0, 0);
        applyStimulus(2, 1, 24'h0000B2, 0);
        expectTx(8'hB0, 4'b0001);
        expectTx(8'hB2, 4'b0100);
        waitGnt("fair_gnt", 4'b0001, 10);
        waitIdle("fair_idle", 100);

        // Frame from requester 3 brings ptr back to 0, then all four contend.
        applyStimulus(3, 1, 24'h0000C3, 0);
        expectTx(8'hC3, 4'b1000);
        waitIdle("cont_prep", 50);
        applyStimulus(0, 2, 24'h001110, 0);
        applyStimulus(0, 2, 24'h001312, 0);
        applyStimulus(1, 2, 24'h002120, 0);
        applyStimulus(2, 2, 24'h003130, 0);
        applyStimulus(3, 2, 24'h004140, 0);
        expectTx(8'h10, 4'b0001);
        expectTx(8'h11, 4'b0001);
        expectTx(8'h20, 4'b0010);
        expectTx(8'h21, 4'b0010);
        expectTx(8'h30, 4'b0100);
        expectTx(8'h31, 4'b0100);
        expectTx(8'h40, 4'b1000);
        expectTx(8'h41, 4'b1000);
        expectTx(8'h12, 4'b0001);
        expectTx(8'h13, 4'b0001);
        waitIdle("cont_idle", 400);

        // Backpressure: requester 1 keeps valid low for 50 granted cycles.
        applyStimulus(1, 1, 24'h000055, 50);
        expectTx(8'h55, 4'b0010);
        waitGnt("bp_gnt", 4'b0010, 10);
        base = txStartCount;
        repeat (50) @(negedge clk);
        checkOutput("bp_no_start", 32'(txStartCount), 32'(base));
        checkOutput("bp_din_held", 32'(tx_din), 32'h13);
        checkOutput("bp_busy", 32'(busy), 1);
        @(negedge clk);
        checkOutput("bp_start", 32'(tx_start), 1);
        waitIdle("bp_idle", 50);

        // Reset while the second of three bytes is on the line.
        base = txStartCount;
        applyStimulus(2, 3, 24'h636261, 0);
        expectTx(8'h61, 4'b0100);
        expectTx(8'h62, 4'b0100);
        expectTx(8'h63, 4'b0100);
        waitCount("rst_second_start", 1'b0, base + 2, 100);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #2;
        checkOutput("midrst_gnt", 32'(gnt), 0);
        checkOutput("midrst_tx_start", 32'(tx_start), 0);
        checkOutput("midrst_busy", 32'(busy), 0);
        checkOutput("midrst_ready", 32'(req_ready), 0);
        @(negedge clk);
        expQ.delete();
        reqQ[2].delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        applyStimulus(1, 1, 24'h000071, 0);
        applyStimulus(3, 1, 24'h000073, 0);
        expectTx(8'h71, 4'b0010);
        expectTx(8'h73, 4'b1000);
        waitGnt("postrst_gnt", 4'b0010, 10);
        waitIdle("postrst_idle", 100);

        checkOutput("sb_empty", 32'(expQ.size()), 0);
        checkOutput("end_abort", 32'(abort_tick), 0);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
